// File: rtl/ni_packet_tx_pkg.sv
// ni_packet_tx_pkg: flit layout, type codes and FSM encoding shared with the router (NI_TX_PARITY_EN selects TX[0] parity)
package ni_packet_tx_pkg;
  localparam int FLIT_W = 32;
  localparam int DEF_LEN_W = 12;
  localparam logic [3:0] DEF_SRC_ADDR = 4'b0001;
  localparam int TYPE_LSB = 29;
  localparam int LEN_LSB = 17;
  localparam int DST_LSB = 13;
  localparam int SRC_LSB = 9;
  localparam int SEQ_LSB = 1;
  typedef enum logic [2:0] {FLIT_HDR = 3'b001, FLIT_BODY = 3'b010, FLIT_TAIL = 3'b100} flit_type_e;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_TAIL, S_GAP} state_e;
endpackage

// File: rtl/ni_packet_tx_if.sv
// ni_packet_tx_if: core command/payload handshake plus the router link (TX/RTS/DCTS)
interface ni_packet_tx_if import ni_packet_tx_pkg::*; #(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int LEN_W = DEF_LEN_W
);
  logic cmd_valid;
  logic cmd_ready;
  logic [3:0] cmd_dst;
  logic [LEN_W-1:0] cmd_len;
  logic pl_valid;
  logic pl_ready;
  logic [DATA_WIDTH-5:0] pl_data;
  logic [DATA_WIDTH-1:0] TX;
  logic RTS;
  logic DCTS;
  logic busy;
  logic pkt_done;
  modport master (
    input cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, DCTS,
    output cmd_ready, pl_ready, TX, RTS, busy, pkt_done
  );
  modport slave (
    output cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, DCTS,
    input cmd_ready, pl_ready, TX, RTS, busy, pkt_done
  );
endinterface

// File: rtl/ni_packet_tx_flit_build.sv
// ni_packet_tx_flit_build: assembles one flit from type and fields; TX[0] is even parity under NI_TX_PARITY_EN, else 0
module ni_packet_tx_flit_build import ni_packet_tx_pkg::*; #(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic [2:0]            ftype_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [3:0]            dst_i,
  input  logic [3:0]            src_i,
  input  logic [7:0]            seq_i,
  input  logic [DATA_WIDTH-5:0] payload_i,
  output logic [DATA_WIDTH-1:0] flit_o
);
  // header packs the routing fields, body/tail carry the payload word
  always_comb begin
    flit_o = '0;
    flit_o[DATA_WIDTH-1:TYPE_LSB] = ftype_i;
    if (ftype_i == FLIT_HDR) begin
      flit_o[LEN_LSB +: LEN_W] = len_i;
      flit_o[DST_LSB +: 4] = dst_i;
      flit_o[SRC_LSB +: 4] = src_i;
      flit_o[SEQ_LSB +: 8] = seq_i;
    end else begin
      flit_o[TYPE_LSB-1:1] = payload_i;
    end
`ifdef NI_TX_PARITY_EN
    flit_o[0] = ^flit_o[DATA_WIDTH-1:1];
`else
    flit_o[0] = 1'b0;
`endif
  end
endmodule

// File: rtl/ni_packet_tx.sv
// ni_packet_tx: network-interface transmitter emitting header/body/tail flits paced by DCTS (NI_TX_PARITY_EN adds parity)
module ni_packet_tx import ni_packet_tx_pkg::*; #(
  parameter int DATA_WIDTH = FLIT_W,
  parameter logic [3:0] SRC_ADDR = DEF_SRC_ADDR,
  parameter int LEN_W = DEF_LEN_W
) (
  input logic clk,
  input logic rst,
  ni_packet_tx_if.master bus
);
  localparam logic [LEN_W-1:0] MAX_LEN = {{(LEN_W-1){1'b1}}, 1'b0};
  state_e state_q, state_d;
  logic [3:0] dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
  logic [7:0] seq_q, seq_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, flit;
  logic rts_q, rts_d, done_q, done_d;
  logic [2:0] ftype;
  logic len_ok, send;
  assign len_ok = bus.cmd_len != '0 && bus.cmd_len <= MAX_LEN;
  assign ftype = state_q == S_HDR ? FLIT_HDR : state_q == S_TAIL ? FLIT_TAIL : FLIT_BODY;
  assign bus.pl_ready = (state_q == S_BODY || state_q == S_TAIL) && bus.DCTS && !rts_q;
  assign send = state_q == S_HDR ? bus.DCTS : bus.pl_ready && bus.pl_valid;
  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.busy = state_q != S_IDLE;
  assign bus.TX = tx_q;
  assign bus.RTS = rts_q;
  assign bus.pkt_done = done_q;
  ni_packet_tx_flit_build #(.DATA_WIDTH(DATA_WIDTH), .LEN_W(LEN_W)) u_build (
    .ftype_i(ftype),
    .len_i(len_q + LEN_W'(1)),
    .dst_i(dst_q),
    .src_i(SRC_ADDR),
    .seq_i(seq_q),
    .payload_i(bus.pl_data),
    .flit_o(flit)
  );
  // next state: every flit is followed by a GAP cycle so RTS never repeats back to back
  always_comb begin
    state_d = state_q;
    dst_d = dst_q;
    len_d = len_q;
    rem_d = rem_q;
    seq_d = seq_q;
    tx_d = tx_q;
    rts_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.cmd_valid && len_ok) begin
        dst_d = bus.cmd_dst;
        len_d = bus.cmd_len;
        rem_d = bus.cmd_len;
        state_d = S_HDR;
      end
      S_HDR, S_BODY, S_TAIL: if (send) begin
        tx_d = flit;
        rts_d = 1'b1;
        rem_d = state_q == S_HDR ? rem_q : rem_q - LEN_W'(1);
        state_d = S_GAP;
      end
      S_GAP: begin
        done_d = rem_q == '0;
        seq_d = rem_q == '0 ? seq_q + 8'd1 : seq_q;
        if (rem_q == '0) state_d = S_IDLE;
        else if (rem_q == LEN_W'(1)) state_d = S_TAIL;
        else state_d = S_BODY;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered link outputs; reset aborts any packet in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dst_q <= '0;
      len_q <= '0;
      rem_q <= '0;
      seq_q <= '0;
      tx_q <= '0;
      rts_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q <= dst_d;
      len_q <= len_d;
      rem_q <= rem_d;
      seq_q <= seq_d;
      tx_q <= tx_d;
      rts_q <= rts_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_ni_packet_tx.sv
// tb_ni_packet_tx: table-driven packets plus backpressure, starvation, illegal command, abort and sequence-wrap sequences
module tb_ni_packet_tx;
  typedef struct {
    logic [3:0] dst;
    logic [11:0] len;
    logic [27:0] base;
    logic [31:0] hdr;
    logic [31:0] first;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  ni_packet_tx_if bus ();
  ni_packet_tx dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int cyc = 0, last_rts = 0, b2b = 0, txc = 0, plr = 0, hs = 0, dones = 0, late = 0;
  int pl_cnt = 0, pl_start = 0;
  logic [27:0] pl_base = '0;
  logic [31:0] prev_tx = '0;
  logic prev_rts = 1'b0;
  logic [31:0] flits[$];
  logic [7:0] seq_model = '0;
  vec_t tbl[4];
  assign bus.pl_data = pl_base + 28'(pl_cnt - pl_start);
  always @(posedge clk) if (rst && bus.pl_ready && bus.pl_valid) pl_cnt <= pl_cnt + 1;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      prev_tx <= '0;
      prev_rts <= 1'b0;
    end else begin
      if (bus.RTS) begin
        flits.push_back(bus.TX);
        last_rts <= cyc;
      end
      if (bus.RTS && prev_rts) b2b <= b2b + 1;
      if (!bus.RTS && bus.TX != prev_tx) txc <= txc + 1;
      if (bus.pl_ready) plr <= plr + 1;
      if (bus.pl_ready && bus.pl_valid) hs <= hs + 1;
      if (bus.pkt_done) begin
        dones <= dones + 1;
        if (cyc != last_rts + 1) late <= late + 1;
      end
      prev_tx <= bus.TX;
      prev_rts <= bus.RTS;
    end
  end
  function automatic logic [31:0] par_fix(input logic [31:0] x);
`ifdef NI_TX_PARITY_EN
    return {x[31:1], ^x[31:1]};
`else
    return {x[31:1], 1'b0};
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_pkt(input int idx, input int mode);
    vec_t v;
    int n, s, plr0, hs0, b2b0, txc0, late0, done0, nbad, viol, cnt;
    logic [31:0] e;
    v = tbl[idx];
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    s = flits.size();
    plr0 = plr; hs0 = hs; b2b0 = b2b; txc0 = txc; late0 = late; done0 = dones;
    pl_base = v.base;
    pl_start = pl_cnt;
    bus.cmd_dst = v.dst;
    bus.cmd_len = v.len;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_drop", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    chk("hdr_latency_rts", 32'(bus.RTS), 1);
    if (mode != 0) begin
      n = 0;
      while (flits.size() - s < 2 && n < 50) begin @(posedge clk); #1; n++; end
      if (mode == 1) bus.DCTS = 1'b0;
      else bus.pl_valid = 1'b0;
      viol = 0;
      repeat (mode == 1 ? 10 : 6) begin
        @(negedge clk);
        if (bus.RTS || (mode == 1 && bus.pl_ready) || !bus.busy) viol++;
      end
      #1;
      chk(mode == 1 ? "backpressure_quiet" : "starve_quiet", viol, 0);
      chk("flits_held", flits.size() - s, 2);
      @(posedge clk); #1;
      bus.DCTS = 1'b1;
      bus.pl_valid = 1'b1;
    end
    n = 0;
    while (dones == done0 && n < 10000) begin @(posedge clk); #1; n++; end
    chk("pkt_done_seen", dones - done0, 1);
    cnt = flits.size() - s;
    chk("flit_count", cnt, 32'(v.len) + 1);
    if (cnt >= 1) chk("header", flits[s], par_fix(v.hdr | (32'(seq_model) << 1)));
    if (cnt >= 2) chk("first_payload", flits[s+1], par_fix(v.first));
    nbad = 0;
    for (int k = 1; k < cnt; k++) begin
      e = par_fix({(k == int'(v.len)) ? 3'b100 : 3'b010, v.base + 28'(k - 1), 1'b0});
      if (flits[s+k] !== e) nbad++;
    end
    chk("payload_flits", nbad, 0);
    chk("pl_handshakes", hs - hs0, 32'(v.len));
    if (mode == 0) chk("pl_ready_cycles", plr - plr0, 32'(v.len));
    chk("rts_back_to_back", b2b - b2b0, 0);
    chk("tx_change_no_rts", txc - txc0, 0);
    chk("pkt_done_late", late - late0, 0);
    seq_model++;
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, viol;
    tbl[0] = '{4'h2, 12'd1, 28'h0ABCDEF, 32'h2004_4200, 32'h8157_9BDE};
    tbl[1] = '{4'h5, 12'd4, 28'h1234567, 32'h200A_A200, 32'h4246_8ACE};
    tbl[2] = '{4'hF, 12'd2, 28'hFFFFFFF, 32'h2007_E200, 32'h5FFF_FFFE};
    tbl[3] = '{4'h0, 12'd4094, 28'h0000100, 32'h3FFE_0200, 32'h4000_0200};
    bus.cmd_valid = 1'b0;
    bus.cmd_dst = '0;
    bus.cmd_len = '0;
    bus.pl_valid = 1'b1;
    bus.DCTS = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.TX, 0);
    chk("rst_rts", 32'(bus.RTS), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_pl_ready", 32'(bus.pl_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pkt_done", 32'(bus.pkt_done), 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) run_pkt(i, 0);
    run_pkt(1, 1);
    run_pkt(1, 2);
    bus.cmd_len = 12'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk("illegal_len0_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_len = 12'd4095;
    @(posedge clk); #1;
    chk("illegal_len4095_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b0;
    viol = 0;
    repeat (4) begin
      @(negedge clk);
      if (!bus.cmd_ready || bus.RTS || bus.busy) viol++;
    end
    chk("illegal_quiet", viol, 0);
    @(posedge clk); #1;
    bus.cmd_dst = 4'h3;
    bus.cmd_len = 12'd4;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.RTS && bus.TX[31:29] == 3'b010) && n < 50) begin @(posedge clk); #1; n++; end
    chk("abort_reached_body", 32'(bus.TX[31:29]), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("abort_tx", bus.TX, 0);
    chk("abort_rts", 32'(bus.RTS), 0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seq_model = '0;
    run_pkt(0, 0);
    for (int i = 0; i < 256; i++) run_pkt(0, 0);
    chk("seq_wrapped_to_1", 32'(seq_model), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ni_packet_tx.md
Name: ni_packet_tx

Overview:
- Network-interface transmitter: the sending end of the router link handshake (TX/RTS out, DCTS in).
- Sits between a local core and a router Local input port (drives L_RX/L_DRTS, samples L_CTS).
- Takes a packet command (destination, payload count) plus a stream of payload words.
- Emits a header flit, body flits and a tail flit in the router flit format, paced by the receiver's clear-to-send.

Parameters:
- DATA_WIDTH, 32, flit width; fixed flit field layout requires 32.
- SRC_ADDR, 4'b0001, this node's address, placed in the header.
- LEN_W, 12, width of the packet-length field.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- cmd_valid  input  1  packet command valid.
- cmd_ready  output  1  block is IDLE and accepts a command.
- cmd_dst  input  4  destination router address.
- cmd_len  input  LEN_W  payload word count; legal range 1..4094.
- pl_valid  input  1  payload word valid.
- pl_ready  output  1  payload word consumed this cycle.
- pl_data  input  28  payload word.
- TX  output  DATA_WIDTH  flit to the router (router RX).
- RTS  output  1  flit strobe (router DRTS, i.e. FIFO write enable).
- DCTS  input  1  receiver clear-to-send (router CTS, i.e. FIFO not full).
- busy  output  1  packet in progress.
- pkt_done  output  1  one-cycle pulse when the tail flit is sent.

Behaviour:
- Flit fields:
  - [31:29] type: HEADER=3'b001, BODY=3'b010, TAIL=3'b100.
  - Header: [28:17] length = cmd_len+1 (total flits); [16:13] dst; [12:9] SRC_ADDR; [8:1] packet sequence number; [0] parity/zero.
  - Body/tail: [28:1] payload; [0] parity/zero.
- Reset (async assert, sync release): state=IDLE, TX=0, RTS=0, cmd_ready=1, pl_ready=0, busy=0, pkt_done=0, sequence=0, counters=0.
- FSM states: IDLE, HDR, BODY, TAIL, GAP.
  - IDLE: cmd_ready=1. cmd_valid&&cmd_ready latches dst and len, sets remaining=cmd_len, then goes to HDR. An illegal cmd_len (0 or >4094) is dropped and the FSM stays IDLE.
  - HDR: if DCTS=1, drive the header on TX and RTS=1 for exactly one cycle (registered outputs), then go to GAP.
  - BODY/TAIL: flit sent when DCTS=1 and pl_valid=1.
    - pl_ready is combinational: pl_ready = (state in BODY/TAIL) && DCTS && !RTS.
    - On the accepting edge, TX is loaded and RTS=1 for one cycle, remaining is decremented, and the FSM goes to GAP.
  - Flit type: remaining==1 sends TAIL, otherwise BODY.
  - GAP: RTS=0 for one cycle so the receiver's updated DCTS is observed. Next state is BODY/TAIL if remaining>0, else IDLE with pkt_done=1 and sequence+1 (wraps 255->0).
- Throughput: at most one flit per 2 cycles; RTS never high on consecutive cycles.
- Latency: command accept to header RTS is 1 cycle when DCTS=1.
- DCTS=0 in HDR/BODY/TAIL: hold state, RTS=0, pl_ready=0, TX holds the last value.
- TX changes only on RTS cycles.
- pl_valid=0 while DCTS=1: wait, no flit sent.
- cmd_len=1: HDR then TAIL (2 flits, length field=2).
- busy=1 in every state except IDLE.
- Reset mid-packet aborts immediately with no tail emitted; the receiver's recovery is out of scope.

Optional Feature:
- Macro: NI_TX_PARITY_EN.
- Defined: TX[0] = even parity over TX[31:1] for every flit type.
- Undefined: TX[0] = 0 constant; no parity logic.

Decomposition:
- Shared package/include (parameters.v): DATA_WIDTH, AXIS, flit type codes, and field offsets (TYPE_LSB=29, LEN_LSB=17, DST_LSB=13, SRC_LSB=9).
- These are the same definitions the router uses for field extraction.
- One natural sub-module: ni_flit_build, combinational. Inputs: type, fields/payload. Output: the 32-bit flit including the parity bit under NI_TX_PARITY_EN.

Test Plan:
- Single-word packet: DCTS=1, cmd_dst=4'b0010, cmd_len=1, pl_data=28'h0ABCDEF.
  - Required: header 0x2004_4200|seq then tail 0x8157_9BDE (bit0 per parity macro).
  - RTS pulses 2, spaced by ≥1 idle cycle; pkt_done one cycle after the tail RTS.
- 4-word packet with DCTS=1: 5 RTS pulses, type sequence 001,010,010,010,100, header length field=5, pl_ready high exactly 4 cycles.
- Backpressure: drop DCTS to 0 for 10 cycles after the 2nd flit.
  - No RTS and no pl_ready while DCTS=0.
  - Resumes with the 3rd flit; no flit lost or duplicated.
- Payload starvation: pl_valid=0 for 6 cycles mid-packet → no RTS, state held, correct flit on resume.
- Illegal commands: cmd_len=0, then cmd_len=4095 → both dropped, cmd_ready stays 1, no RTS.
- Abort and recovery: assert rst low mid-BODY → TX=0, RTS=0, cmd_ready=1 asynchronously; the next packet's header carries seq=0.
- Sequence wrap: 256 back-to-back packets → seq field wraps 255→0.
